line_cmd_queue: RTL
===================

Name: line_cmd_queue

Overview:
- Upstream feeder for the line engine.
- Accepts memory-mapped CPU stores (color, start point, end point) and buffers complete line commands in a small FIFO.
- Replays each command to the line engine using its color/x0y0/x1y1-valid and trigger protocol, gated on LE_ready.
- Decouples CPU store rate from line drawing time, so the CPU stalls only when the queue is full.

Parameters:
- DEPTH, 4, number of buffered line commands (power of two, >=2)
- PTR_W, 2, log2(DEPTH)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- mmio_we  in  1  CPU store strobe, one cycle per store
- mmio_addr  in  2  word offset: 0=color, 1=point0, 2=point1 (enqueue), 3=clear overflow
- mmio_wdata  in  32  store data; points use [19:10]=x, [9:0]=y
- mmio_ready  out  1  queue not full
- q_count  out  PTR_W+1  entries currently queued
- overflow  out  1  sticky: a point1 store was dropped because the queue was full
- busy  out  1  queue non-empty or FSM not IDLE
- LE_ready  in  1  line engine idle
- LE_color  out  32  color to line engine
- LE_point  out  20  {x,y} to line engine
- LE_color_valid  out  1  color strobe
- LE_x0_y0_valid  out  1  start point strobe
- LE_x1_y1_valid  out  1  end point strobe
- LE_trigger  out  1  start draw, asserted with LE_x1_y1_valid

Behaviour:
- Reset (rst low, async):
  - All outputs 0 except mmio_ready=1.
  - Queue emptied; color_stage and p0_stage cleared; FSM to IDLE.
  - Reset mid-command abandons the command; the line engine has its own reset.
- Staging:
  - Store to offset 0 writes color_stage.
  - Store to offset 1 writes p0_stage (mmio_wdata[19:0]).
- Enqueue:
  - Store to offset 2 pushes the 72-bit entry {color_stage, p0_stage, mmio_wdata[19:0]} when not full.
  - If the queue is full, the entry is dropped, overflow is set, and the queue is unchanged.
  - A push in the same cycle as a pop when full is still dropped; full is evaluated before the pop.
- Store to offset 3 clears overflow. Stores with mmio_we low are ignored.
- Queue:
  - Circular buffer; read/write pointers PTR_W+1 bits with a wrap bit.
  - full when pointers are equal except the MSB; empty when pointers are identical.
  - q_count = wptr - rptr (modulo 2^(PTR_W+1)), registered result of the pointer update.
- FSM states: IDLE, SEND_COLOR, SEND_P0, SEND_P1, GUARD.
  - IDLE: if !empty && LE_ready, go to SEND_COLOR. Load LE_color and LE_point from the head entry at this transition.
  - SEND_COLOR: LE_color_valid=1 for one cycle, then SEND_P0. LE_point=p0 is registered on this edge.
  - SEND_P0: LE_x0_y0_valid=1 for one cycle, then SEND_P1. LE_point=p1 is registered.
  - SEND_P1: LE_x1_y1_valid=1 and LE_trigger=1 for one cycle. Pop the head entry (rptr+1); go to GUARD.
  - GUARD: one cycle with all strobes low, covering the cycle before LE_ready falls. Then IDLE.
- Strobes are registered and exactly one cycle wide. LE_color and LE_point remain stable during their strobe cycle.
- Latency:
  - A point1 store at edge N makes the entry visible at N+1.
  - With LE_ready high, LE_color_valid is high in cycle N+2, x0y0 in N+3, x1y1/trigger in N+4.
- Back-to-back lines: the next SEND_COLOR starts the first cycle after GUARD in which LE_ready=1.
- LE_ready low in IDLE holds the FSM in IDLE indefinitely; no timeout.
- busy = !empty || state != IDLE.

Optional Feature:
- Macro LINE_CMD_POLYLINE_EN.
- Defined: every accepted point1 store also copies its point into p0_stage. Successive point1 stores then draw a connected polyline from a single point0 store.
- Not defined: p0_stage changes only on offset-1 stores.
- A dropped (overflow) store never updates p0_stage in either mode.

Decomposition:
- Shared package holds:
  - mmio offset constants (OFF_COLOR=0, OFF_P0=1, OFF_P1=2, OFF_CLR=3)
  - FSM state encoding
  - entry field positions (color [71:40], p0 [39:20], p1 [19:0])
  - point field widths (X_W=10, Y_W=10)
- One sub-module is natural: line_cmd_fifo, a generic DEPTH x 72 circular FIFO with push/pop/full/empty/count. The top level holds the staging registers, overflow flag and FSM.

Test Plan:
- Single line: stores color=0x007F0000, p0={0,0}, p1={400,652}, LE_ready=1 → color_valid, x0y0_valid, x1y1_valid+trigger in consecutive cycles N+2..N+4 with matching LE_color/LE_point; q_count returns to 0.
- Backpressure: LE_ready=0, enqueue 4 lines → mmio_ready=0, q_count=4. A fifth point1 store → overflow=1 and q_count stays 4. Offset-3 store clears overflow.
- Drain ordering: with LE_ready toggling (low 20 cycles after each trigger), 4 queued lines with distinct endpoints reach the line engine in FIFO order, each sequence starting only when LE_ready=1.
- Pointer wrap: push/pop 10 lines with DEPTH=4 → all delivered intact; full/empty correct across the wrap.
- Reset mid-command: assert rst low during SEND_P0 → all strobes 0 immediately, q_count=0, mmio_ready=1. After release, a new line is sent from the start.
- Polyline (LINE_CMD_POLYLINE_EN): p0={10,10}, then p1 stores {20,20} and {30,5} → second line has x0y0={20,20}. Without the macro it is {10,10}.

Source files
------------

// File: rtl/line_cmd_queue_pkg.sv
// Shared constants for the line command queue: MMIO offsets, FSM encoding and
// the layout of a queued 72-bit line entry.
package line_cmd_queue_pkg;

  localparam logic [1:0] OFF_COLOR = 2'd0;
  localparam logic [1:0] OFF_P0    = 2'd1;
  localparam logic [1:0] OFF_P1    = 2'd2;
  localparam logic [1:0] OFF_CLR   = 2'd3;

  localparam int X_W       = 10;
  localparam int Y_W       = 10;
  localparam int PT_W      = X_W + Y_W;
  localparam int COLOR_W   = 32;
  localparam int ENTRY_W   = COLOR_W + 2 * PT_W;
  localparam int P1_LSB    = 0;
  localparam int P0_LSB    = PT_W;
  localparam int COLOR_LSB = 2 * PT_W;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SEND_COLOR = 3'd1,
    ST_SEND_P0    = 3'd2,
    ST_SEND_P1    = 3'd3,
    ST_GUARD      = 3'd4
  } line_state_e;

  function automatic logic [ENTRY_W-1:0] pack_entry(input logic [COLOR_W-1:0] color,
                                                    input logic [PT_W-1:0] p0,
                                                    input logic [PT_W-1:0] p1);
    return {color, p0, p1};
  endfunction

endpackage

// File: rtl/line_cmd_fifo.sv
// Generic DEPTH x W circular FIFO; pointers carry a wrap bit so full and empty
// are distinguished without a separate counter. Push when full is ignored.
module line_cmd_fifo
  import line_cmd_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int W     = ENTRY_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  logic           pop,
  input  logic [W-1:0]   wdata,
  output logic [W-1:0]   rdata,
  output logic           full,
  output logic           empty,
  output logic [PTR_W:0] count
);

  logic [PTR_W:0] wptr_q, wptr_d;
  logic [PTR_W:0] rptr_q, rptr_d;
  logic [PTR_W:0] count_q, count_d;
  logic [W-1:0]   mem_q [DEPTH];
  logic           do_push, do_pop;

  assign full  = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                 (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
  assign empty = (wptr_q == rptr_q);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (do_push) wptr_d = wptr_q + (PTR_W + 1)'(1);
    if (do_pop)  rptr_d = rptr_q + (PTR_W + 1)'(1);
    count_d = wptr_d - rptr_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[PTR_W-1:0]] <= wdata;
  end

  assign rdata = mem_q[rptr_q[PTR_W-1:0]];
  assign count = count_q;

endmodule

// File: rtl/line_cmd_queue.sv
// MMIO-fed line command queue replaying buffered lines to the line engine.
// Define LINE_CMD_POLYLINE_EN to make each accepted point1 store also become the next point0.
module line_cmd_queue
  import line_cmd_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mmio_we,
  input  logic [1:0]         mmio_addr,
  input  logic [31:0]        mmio_wdata,
  output logic               mmio_ready,
  output logic [PTR_W:0]     q_count,
  output logic               overflow,
  output logic               busy,
  input  logic               LE_ready,
  output logic [COLOR_W-1:0] LE_color,
  output logic [PT_W-1:0]    LE_point,
  output logic               LE_color_valid,
  output logic               LE_x0_y0_valid,
  output logic               LE_x1_y1_valid,
  output logic               LE_trigger,
  output line_state_e        dbg_state
);

  logic [COLOR_W-1:0] color_stage_q, color_stage_d;
  logic [PT_W-1:0]    p0_stage_q, p0_stage_d;
  logic               overflow_q, overflow_d;
  logic               push_req, fifo_full, fifo_empty, pop;
  logic [ENTRY_W-1:0] head;
  line_state_e        state_q;
  logic [COLOR_W-1:0] le_color_q;
  logic [PT_W-1:0]    le_point_q;
  logic               color_valid_q, x0_valid_q, x1_valid_q, trigger_q;

  assign push_req = mmio_we && (mmio_addr == OFF_P1);
  assign pop      = (state_q == ST_SEND_P1);

  line_cmd_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W), .W(ENTRY_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (pop),
    .wdata (pack_entry(color_stage_q, p0_stage_q, mmio_wdata[PT_W-1:0])),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (q_count)
  );

  // Full is sampled before this cycle's pop, so a push racing a pop when full is dropped.
  always_comb begin
    color_stage_d = color_stage_q;
    p0_stage_d    = p0_stage_q;
    overflow_d    = overflow_q;
    if (mmio_we) begin
      case (mmio_addr)
        OFF_COLOR: color_stage_d = mmio_wdata;
        OFF_P0:    p0_stage_d    = mmio_wdata[PT_W-1:0];
        OFF_P1: begin
          if (fifo_full) overflow_d = 1'b1;
`ifdef LINE_CMD_POLYLINE_EN
          else p0_stage_d = mmio_wdata[PT_W-1:0];
`endif
        end
        default:   overflow_d    = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      color_stage_q <= '0;
      p0_stage_q    <= '0;
      overflow_q    <= 1'b0;
    end else begin
      color_stage_q <= color_stage_d;
      p0_stage_q    <= p0_stage_d;
      overflow_q    <= overflow_d;
    end
  end

  // Line engine handshake: each strobe is a registered one-cycle pulse with its data
  // stable in that cycle; a new command starts only from IDLE while LE_ready is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      le_color_q    <= '0;
      le_point_q    <= '0;
      color_valid_q <= 1'b0;
      x0_valid_q    <= 1'b0;
      x1_valid_q    <= 1'b0;
      trigger_q     <= 1'b0;
    end else begin
      color_valid_q <= 1'b0;
      x0_valid_q    <= 1'b0;
      x1_valid_q    <= 1'b0;
      trigger_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty && LE_ready) begin
            state_q       <= ST_SEND_COLOR;
            le_color_q    <= head[COLOR_LSB +: COLOR_W];
            le_point_q    <= head[P0_LSB +: PT_W];
            color_valid_q <= 1'b1;
          end
        end
        ST_SEND_COLOR: begin
          state_q    <= ST_SEND_P0;
          le_point_q <= head[P0_LSB +: PT_W];
          x0_valid_q <= 1'b1;
        end
        ST_SEND_P0: begin
          state_q    <= ST_SEND_P1;
          le_point_q <= head[P1_LSB +: PT_W];
          x1_valid_q <= 1'b1;
          trigger_q  <= 1'b1;
        end
        ST_SEND_P1: state_q <= ST_GUARD;
        default:    state_q <= ST_IDLE;
      endcase
    end
  end

  assign mmio_ready     = !fifo_full;
  assign overflow       = overflow_q;
  assign busy           = !fifo_empty || (state_q != ST_IDLE);
  assign LE_color       = le_color_q;
  assign LE_point       = le_point_q;
  assign LE_color_valid = color_valid_q;
  assign LE_x0_y0_valid = x0_valid_q;
  assign LE_x1_y1_valid = x1_valid_q;
  assign LE_trigger     = trigger_q;
  assign dbg_state      = state_q;

endmodule
